ysyx_22040750_clint: RTL and testbench

//  Core-local interruptor for the ysyx_22040750 core: MMIO msip/mtimecmp/mtime registers.

---
 rtl/ysyx_22040750_clint.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_22040750_clint.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_clint.sv
// Core-local interruptor: msip/mtimecmp/mtime MMIO registers plus a held trap request to the CSR logic.
// Bus handshake: a beat transfers on a rising edge with I_bus_valid & O_bus_ready; a read answers with a one-cycle O_bus_rvalid pulse on the following cycle.
module ysyx_22040750_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        I_bus_valid,
    input  logic        I_bus_wen,
    input  logic [31:0] I_bus_addr,
    input  logic [63:0] I_bus_wdata,
    input  logic [7:0]  I_bus_wmask,
    output logic        O_bus_ready,
    output logic        O_bus_rvalid,
    output logic [63:0] O_bus_rdata,
    input  logic        I_mstatus_mie,
    input  logic [63:0] I_mie,
    output logic [63:0] O_mip,
    output logic        O_intr_req,
    output logic [63:0] O_intr_no,
    input  logic        I_intr_ack,
    output logic [1:0]  O_dbg_state
);

    localparam logic [31:0] MSIP_ADDR     = BASE_ADDR;
    localparam logic [31:0] MTIMECMP_ADDR = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] MTIME_ADDR    = BASE_ADDR + 32'h0000_BFF8;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [63:0] NO_SOFT = {1'b1, 58'b0, 5'd3};
    localparam logic [63:0] NO_TIM  = {1'b1, 58'b0, 5'd7};

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [PW-1:0] presc;
    logic          mtip_q;
    logic          msip_q;
    logic [1:0]    state;
    logic          src_soft;

    logic          bus_wr;
    logic          bus_rd;
    logic          sel_msip;
    logic          sel_cmp;
    logic          sel_mtime;
    logic          tick;
    logic [63:0]   bit_mask;
    logic [63:0]   rd_mux;
    logic          soft_en;
    logic          tim_en;
    logic          unused_mie_bits;

    assign bus_wr    = I_bus_valid & O_bus_ready & I_bus_wen;
    assign bus_rd    = I_bus_valid & O_bus_ready & ~I_bus_wen;
    assign sel_msip  = (I_bus_addr == MSIP_ADDR);
    assign sel_cmp   = (I_bus_addr == MTIMECMP_ADDR);
    assign sel_mtime = (I_bus_addr == MTIME_ADDR);
    assign tick      = (presc == PRESC_MAX);

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{I_bus_wmask[i]}};
        end
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_mux = '0;
        if (sel_msip) begin
            rd_mux = {63'b0, msip};
        end else if (sel_cmp) begin
            rd_mux = mtimecmp;
        end else if (sel_mtime) begin
            rd_mux = mtime;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_bus_ready  <= 1'b0;
            O_bus_rvalid <= 1'b0;
            O_bus_rdata  <= '0;
        end else begin
            O_bus_ready  <= 1'b1;
            O_bus_rvalid <= bus_rd;
            if (bus_rd) begin
                O_bus_rdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else begin
            if (bus_wr && sel_msip && I_bus_wmask[0]) begin
                msip <= I_bus_wdata[0];
            end
            if (bus_wr && sel_cmp) begin
                mtimecmp <= (mtimecmp & ~bit_mask) | (I_bus_wdata & bit_mask);
            end
        end
    end

    // A software write to mtime swallows the tick of that cycle; the prescaler keeps running.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (bus_wr && sel_mtime) begin
                mtime <= (mtime & ~bit_mask) | (I_bus_wdata & bit_mask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mtip_q <= 1'b0;
            msip_q <= 1'b0;
        end else begin
            mtip_q <= (mtime >= mtimecmp);
            msip_q <= msip;
        end
    end

    assign O_mip = {56'b0, mtip_q, 3'b0, msip_q, 3'b0};

    assign soft_en = I_mstatus_mie & I_mie[3] & msip_q;
    assign tim_en  = I_mstatus_mie & I_mie[7] & mtip_q;

    assign unused_mie_bits = ^{I_mie[63:8], I_mie[6:4], I_mie[2:0]};

    // CLEAR parks until the serviced source's pending bit drops, so one event traps once.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= ST_IDLE;
            O_intr_req <= 1'b0;
            O_intr_no  <= '0;
            src_soft   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (soft_en || tim_en) begin
                        O_intr_req <= 1'b1;
                        O_intr_no  <= soft_en ? NO_SOFT : NO_TIM;
                        src_soft   <= soft_en;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (I_intr_ack) begin
                        O_intr_req <= 1'b0;
                        state      <= ST_CLEAR;
                    end else if (src_soft ? !soft_en : !tim_en) begin
                        O_intr_req <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (src_soft ? !msip_q : !mtip_q) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    O_intr_req <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_dbg_state = state;

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Self-checking bench for ysyx_22040750_clint: register table, randomized bus traffic against a
// cycle model of the timer registers, and directed interrupt-handshake sequences.
module tb_ysyx_22040750_clint;

    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam int          TICK_DIV = 1;
    localparam logic [31:0] A_MSIP   = BASE;
    localparam logic [31:0] A_CMP    = BASE + 32'h0000_4000;
    localparam logic [31:0] A_MTIME  = BASE + 32'h0000_BFF8;
    localparam logic [31:0] A_UNMAP  = BASE + 32'h0000_0008;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_REQ    = 2'd1;
    localparam logic [1:0]  S_CLEAR  = 2'd2;
    localparam logic [63:0] NO_SOFT  = 64'h8000_0000_0000_0003;
    localparam logic [63:0] NO_TIM   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        I_sys_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_bus_valid, I_bus_wen;
    logic [31:0] I_bus_addr;
    logic [63:0] I_bus_wdata;
    logic [7:0]  I_bus_wmask;
    logic        O_bus_ready, O_bus_rvalid;
    logic [63:0] O_bus_rdata;
    logic        I_mstatus_mie;
    logic [63:0] I_mie;
    logic [63:0] O_mip;
    logic        O_intr_req;
    logic [63:0] O_intr_no;
    logic        I_intr_ack;
    logic [1:0]  O_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    ysyx_22040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(TICK_DIV)) dut (
        .I_sys_clk(I_sys_clk), .I_rst_n(I_rst_n),
        .I_bus_valid(I_bus_valid), .I_bus_wen(I_bus_wen), .I_bus_addr(I_bus_addr),
        .I_bus_wdata(I_bus_wdata), .I_bus_wmask(I_bus_wmask),
        .O_bus_ready(O_bus_ready), .O_bus_rvalid(O_bus_rvalid), .O_bus_rdata(O_bus_rdata),
        .I_mstatus_mie(I_mstatus_mie), .I_mie(I_mie), .O_mip(O_mip),
        .O_intr_req(O_intr_req), .O_intr_no(O_intr_no), .I_intr_ack(I_intr_ack),
        .O_dbg_state(O_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 I_sys_clk = ~I_sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [63:0]     m_mtime, m_cmp;
    logic            m_msip, m_mtip, m_msip_p;
    longint unsigned m_edges;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        if (a == A_MSIP)  return {63'b0, m_msip};
        if (a == A_CMP)   return m_cmp;
        if (a == A_MTIME) return m_mtime;
        return 64'd0;
    endfunction

    always @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            m_mtime  <= 64'd0;
            m_cmp    <= ALL1;
            m_msip   <= 1'b0;
            m_mtip   <= 1'b0;
            m_msip_p <= 1'b0;
            m_edges  <= 0;
            exp_q.delete();
        end else begin
            m_edges  <= m_edges + 1;
            m_mtip   <= (m_mtime >= m_cmp);
            m_msip_p <= m_msip;
            if (I_bus_valid && !I_bus_wen) exp_q.push_back(model_read(I_bus_addr));
            if (I_bus_valid && I_bus_wen && I_bus_addr == A_MSIP && I_bus_wmask[0])
                m_msip <= I_bus_wdata[0];
            if (I_bus_valid && I_bus_wen && I_bus_addr == A_CMP)
                m_cmp <= merge(m_cmp, I_bus_wdata, I_bus_wmask);
            if (I_bus_valid && I_bus_wen && I_bus_addr == A_MTIME)
                m_mtime <= merge(m_mtime, I_bus_wdata, I_bus_wmask);
            else if ((m_edges % TICK_DIV) == TICK_DIV - 1)
                m_mtime <= m_mtime + 64'd1;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge I_sys_clk) begin
        chk("mip", O_mip, {56'b0, m_mtip, 3'b0, m_msip_p, 3'b0});
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wait_ready();
        int k = 0;
        while (O_bus_ready !== 1'b1 && k < 20) begin
            @(negedge I_sys_clk);
            k++;
        end
        chk("bus_ready", {63'b0, O_bus_ready}, 64'd1);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        wait_ready();
        I_bus_valid = 1'b1; I_bus_wen = 1'b1;
        I_bus_addr = a; I_bus_wdata = d; I_bus_wmask = m;
        @(negedge I_sys_clk);
        I_bus_valid = 1'b0; I_bus_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [63:0] d);
        logic [63:0] e;
        wait_ready();
        I_bus_valid = 1'b1; I_bus_wen = 1'b0; I_bus_addr = a;
        @(negedge I_sys_clk);
        I_bus_valid = 1'b0;
        chk("rvalid", {63'b0, O_bus_rvalid}, 64'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("rdata", O_bus_rdata, e);
        end
        d = O_bus_rdata;
    endtask

    task automatic ack_pulse();
        I_intr_ack = 1'b1;
        @(negedge I_sys_clk);
        I_intr_ack = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return A_MSIP;
            1:       return A_CMP;
            2:       return A_MTIME;
            3:       return A_UNMAP;
            default: return BASE + 32'h0000_4008;
        endcase
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [63:0] init;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp;
    } vec_t;

    vec_t        tab[7];
    logic [63:0] rd;
    int          k;

    initial begin
        tab[0] = '{A_CMP,   64'hAAAA_AAAA_BBBB_BBBB, 64'h1122_3344_5566_7788, 8'h0F, 64'hAAAA_AAAA_5566_7788};
        tab[1] = '{A_CMP,   64'h0,                   64'h1122_3344_5566_7788, 8'hF0, 64'h1122_3344_0000_0000};
        tab[2] = '{A_CMP,   ALL1,                    64'h0,                   8'h81, 64'h00FF_FFFF_FFFF_FF00};
        tab[3] = '{A_MSIP,  64'h0,                   ALL1,                    8'hFF, 64'h1};
        tab[4] = '{A_MSIP,  64'h1,                   64'h0,                   8'hFE, 64'h1};
        tab[5] = '{A_MSIP,  64'h1,                   64'h0,                   8'h01, 64'h0};
        tab[6] = '{A_UNMAP, ALL1,                    64'h1234_5678_9ABC_DEF0, 8'hFF, 64'h0};

        I_bus_valid = 0; I_bus_wen = 0; I_bus_addr = 0; I_bus_wdata = 0; I_bus_wmask = 0;
        I_mstatus_mie = 0; I_mie = 0; I_intr_ack = 0;

        // T1: reset values
        repeat (3) @(negedge I_sys_clk);
        chk("rst_ready",  {63'b0, O_bus_ready},  64'd0);
        chk("rst_rvalid", {63'b0, O_bus_rvalid}, 64'd0);
        chk("rst_rdata",  O_bus_rdata,           64'd0);
        chk("rst_req",    {63'b0, O_intr_req},   64'd0);
        chk("rst_no",     O_intr_no,             64'd0);
        chk("rst_state",  {62'b0, O_dbg_state},  {62'b0, S_IDLE});
        I_rst_n = 1'b1;
        bus_read(A_CMP, rd);
        chk("t1_mtimecmp", rd, ALL1);
        bus_read(A_MTIME, rd);

        // T5 part: masked merges, msip bit0 only, unmapped space
        foreach (tab[i]) begin
            bus_write(tab[i].addr, tab[i].init, 8'hFF);
            bus_write(tab[i].addr, tab[i].wdata, tab[i].wmask);
            bus_read(tab[i].addr, rd);
            chk($sformatf("table%0d", i), rd, tab[i].exp);
        end

        // randomized bus traffic with interrupts globally disabled
        for (int n = 0; n < 80; n++) begin
            I_mie = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0, 1:    bus_write(rand_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
                2, 3:    bus_read(rand_addr(), rd);
                default: repeat ($urandom_range(1, 3)) @(negedge I_sys_clk);
            endcase
            chk("rand_req", {63'b0, O_intr_req}, 64'd0);
        end

        // T2: timer interrupt, ack, clear-by-rewrite
        I_mie = 64'h80; I_mstatus_mie = 1'b0;
        bus_write(A_CMP, ALL1, 8'hFF);
        bus_write(A_MSIP, 64'd0, 8'hFF);
        bus_write(A_MTIME, 64'd0, 8'hFF);
        bus_write(A_CMP, 64'd10, 8'hFF);
        I_mstatus_mie = 1'b1;
        k = 0;
        while (!O_mip[7] && k < 50) begin @(negedge I_sys_clk); k++; end
        chk("t2_mip_seen", {63'b0, O_mip[7]}, 64'd1);
        chk("t2_mip_mtime", m_mtime, 64'd11);
        chk("t2_req_lag", {63'b0, O_intr_req}, 64'd0);
        @(negedge I_sys_clk);
        chk("t2_req", {63'b0, O_intr_req}, 64'd1);
        chk("t2_no", O_intr_no, NO_TIM);
        repeat (2) @(negedge I_sys_clk);
        chk("t2_req_held", {63'b0, O_intr_req}, 64'd1);
        chk("t2_no_held", O_intr_no, NO_TIM);
        ack_pulse();
        chk("t2_req_ack", {63'b0, O_intr_req}, 64'd0);
        chk("t2_state_clear", {62'b0, O_dbg_state}, {62'b0, S_CLEAR});
        for (int i = 0; i < 5; i++) begin
            @(negedge I_sys_clk);
            chk("t2_blocked", {63'b0, O_intr_req}, 64'd0);
        end
        bus_write(A_CMP, 64'd100, 8'hFF);
        k = 0;
        while (!O_intr_req && k < 200) begin @(negedge I_sys_clk); k++; end
        chk("t2_rereq", {63'b0, O_intr_req}, 64'd1);
        chk("t2_rereq_mtime", m_mtime, 64'd102);
        chk("t2_rereq_no", O_intr_no, NO_TIM);
        ack_pulse();
        bus_write(A_CMP, ALL1, 8'hFF);
        repeat (3) @(negedge I_sys_clk);
        chk("t2_idle", {62'b0, O_dbg_state}, {62'b0, S_IDLE});
        chk("t2_quiet", {63'b0, O_intr_req}, 64'd0);

        // T3: software beats timer, timer follows once msip clears
        I_mstatus_mie = 1'b0; I_mie = 64'h88;
        bus_write(A_MSIP, 64'd1, 8'h01);
        bus_write(A_CMP, 64'd0, 8'hFF);
        repeat (2) @(negedge I_sys_clk);
        chk("t3_mip_both", O_mip, 64'h88);
        I_mstatus_mie = 1'b1;
        @(negedge I_sys_clk);
        chk("t3_req", {63'b0, O_intr_req}, 64'd1);
        chk("t3_no_soft", O_intr_no, NO_SOFT);
        ack_pulse();
        chk("t3_req_ack", {63'b0, O_intr_req}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge I_sys_clk);
            chk("t3_blocked", {63'b0, O_intr_req}, 64'd0);
        end
        bus_write(A_MSIP, 64'd0, 8'h01);
        k = 0;
        while (!O_intr_req && k < 20) begin @(negedge I_sys_clk); k++; end
        chk("t3_timer_req", {63'b0, O_intr_req}, 64'd1);
        chk("t3_no_tim", O_intr_no, NO_TIM);
        ack_pulse();
        I_mstatus_mie = 1'b0;
        bus_write(A_CMP, ALL1, 8'hFF);
        repeat (3) @(negedge I_sys_clk);
        chk("t3_idle", {62'b0, O_dbg_state}, {62'b0, S_IDLE});

        // T4: masking and enable drop before ack
        I_mie = 64'h80;
        bus_write(A_CMP, 64'd0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge I_sys_clk);
            chk("t4_masked", {63'b0, O_intr_req}, 64'd0);
        end
        I_mstatus_mie = 1'b1;
        @(negedge I_sys_clk);
        chk("t4_req", {63'b0, O_intr_req}, 64'd1);
        chk("t4_state_req", {62'b0, O_dbg_state}, {62'b0, S_REQ});
        I_mstatus_mie = 1'b0;
        @(negedge I_sys_clk);
        chk("t4_drop", {63'b0, O_intr_req}, 64'd0);
        chk("t4_state_idle", {62'b0, O_dbg_state}, {62'b0, S_IDLE});
        for (int i = 0; i < 3; i++) begin
            @(negedge I_sys_clk);
            chk("t4_stays_low", {63'b0, O_intr_req}, 64'd0);
        end

        // T5: mtime write on a tick cycle wins; unmapped read
        bus_write(A_MTIME, 64'h1000, 8'hFF);
        bus_read(A_MTIME, rd);
        chk("t5_mtime_write_wins", rd, 64'h1000);
        bus_read(A_UNMAP, rd);
        chk("t5_unmapped", rd, 64'd0);

        // T6: mtime wraps modulo 2^64
        bus_write(A_MTIME, ALL1, 8'hFF);
        bus_read(A_MTIME, rd);
        chk("t6_mtime_max", rd, ALL1);
        bus_read(A_MTIME, rd);
        chk("t6_mtime_wrap", rd, 64'd0);

        // T6: asynchronous reset while a request is held
        bus_write(A_CMP, 64'd0, 8'hFF);
        repeat (2) @(negedge I_sys_clk);
        I_mstatus_mie = 1'b1;
        @(negedge I_sys_clk);
        chk("t6_req", {63'b0, O_intr_req}, 64'd1);
        #2 I_rst_n = 1'b0;
        #1;
        chk("t6_async_req", {63'b0, O_intr_req}, 64'd0);
        chk("t6_async_no", O_intr_no, 64'd0);
        chk("t6_async_ready", {63'b0, O_bus_ready}, 64'd0);
        chk("t6_async_state", {62'b0, O_dbg_state}, {62'b0, S_IDLE});
        repeat (2) @(negedge I_sys_clk);
        I_rst_n = 1'b1;
        bus_read(A_CMP, rd);
        chk("t6_cmp_after_rst", rd, ALL1);
        for (int i = 0; i < 3; i++) begin
            @(negedge I_sys_clk);
            chk("t6_req_after_rst", {63'b0, O_intr_req}, 64'd0);
        end
        I_mstatus_mie = 1'b0;
        @(negedge I_sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
